// File: rtl/external_rx_gearbox_sync_if.sv
// GTX RX gearbox side-band bundle for external_rx_gearbox_sync.
// master drives the gearbox inputs; slave is the block-lock/sync logic.
interface external_rx_gearbox_sync_if;
    logic [31:0] i_data;
    logic [1:0]  i_header;
    logic        i_header_valid;
    logic        i_datavalid;
    logic        o_rxgearboxslip;
    logic        o_block_lock;
    logic [31:0] o_data;
    logic [1:0]  o_header;
    logic        o_start_of_block;
    logic        o_data_valid;
    logic [15:0] o_bad_header_count;

    modport master (
        output i_data, i_header, i_header_valid, i_datavalid,
        input  o_rxgearboxslip, o_block_lock, o_data, o_header, o_start_of_block,
               o_data_valid, o_bad_header_count
    );

    modport slave (
        input  i_data, i_header, i_header_valid, i_datavalid,
        output o_rxgearboxslip, o_block_lock, o_data, o_header, o_start_of_block,
               o_data_valid, o_bad_header_count
    );
endinterface

// File: rtl/external_rx_gearbox_sync.sv
// 64b/66b block-lock FSM and registered datapath behind the GTX built-in RX gearbox.
// Optional invalid-header statistics counter enabled by defining RX_GEARBOX_STATS_EN.
module external_rx_gearbox_sync #(
    parameter int unsigned SH_CNT_MAX       = 64,
    parameter int unsigned SH_INVALID_MAX   = 16,
    parameter int unsigned SLIP_WAIT_CYCLES = 32
) (
    input  logic                             i_usrclk2,
    input  logic                             i_rst_n,
    external_rx_gearbox_sync_if.slave        bus
);

    localparam int unsigned SH_CNT_W    = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned SH_INV_W    = $clog2(SH_INVALID_MAX + 1);
    localparam int unsigned SLIP_WAIT_W = (SLIP_WAIT_CYCLES > 1) ? $clog2(SLIP_WAIT_CYCLES) : 1;

    localparam logic [2:0] LOCK_INIT = 3'd0;
    localparam logic [2:0] RESET_CNT = 3'd1;
    localparam logic [2:0] TEST_SH   = 3'd2;
    localparam logic [2:0] SLIP      = 3'd3;
    localparam logic [2:0] WAIT_SLIP = 3'd4;

    logic [2:0]             state_q, state_d;
    logic                   lock_q, lock_d;
    logic [SH_CNT_W-1:0]    sh_cnt_q, sh_cnt_d, sh_cnt_inc;
    logic [SH_INV_W-1:0]    sh_inv_q, sh_inv_d, sh_inv_inc;
    logic [SLIP_WAIT_W-1:0] slip_wait_q, slip_wait_d;
    logic                   slip_q;

    logic                   test_event;
    logic                   hdr_invalid;

    logic [31:0]            data_q;
    logic [1:0]             header_q;
    logic                   sob_q;
    logic                   data_valid_q;

    assign test_event  = bus.i_header_valid && bus.i_datavalid;
    // 2'b00 and 2'b11 are the only illegal sync headers
    assign hdr_invalid = (bus.i_header[1] == bus.i_header[0]);

    assign sh_cnt_inc = sh_cnt_q + SH_CNT_W'(1);
    assign sh_inv_inc = sh_inv_q + SH_INV_W'(hdr_invalid);

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        sh_cnt_d    = sh_cnt_q;
        sh_inv_d    = sh_inv_q;
        slip_wait_d = slip_wait_q;
        case (state_q)
            LOCK_INIT: begin
                lock_d  = 1'b0;
                state_d = RESET_CNT;
            end
            RESET_CNT: begin
                sh_cnt_d = '0;
                sh_inv_d = '0;
                state_d  = TEST_SH;
            end
            TEST_SH: begin
                if (test_event) begin
                    sh_cnt_d = sh_cnt_inc;
                    sh_inv_d = sh_inv_inc;
                    if (!lock_q) begin
                        if (hdr_invalid) begin
                            state_d = SLIP;
                        end else if (sh_cnt_inc == SH_CNT_W'(SH_CNT_MAX)) begin
                            lock_d  = 1'b1;
                            state_d = RESET_CNT;
                        end
                    end else if (sh_inv_inc == SH_INV_W'(SH_INVALID_MAX)) begin
                        // Too many bad headers wins over a window ending on the same event
                        lock_d  = 1'b0;
                        state_d = SLIP;
                    end else if (sh_cnt_inc == SH_CNT_W'(SH_CNT_MAX)) begin
                        state_d = RESET_CNT;
                    end
                end
            end
            SLIP: begin
                slip_wait_d = '0;
                state_d     = WAIT_SLIP;
            end
            WAIT_SLIP: begin
                if (slip_wait_q == SLIP_WAIT_W'(SLIP_WAIT_CYCLES - 1)) begin
                    state_d = RESET_CNT;
                end else begin
                    slip_wait_d = slip_wait_q + SLIP_WAIT_W'(1);
                end
            end
            default: begin
                state_d = LOCK_INIT;
            end
        endcase
    end

    always_ff @(posedge i_usrclk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= LOCK_INIT;
            lock_q      <= 1'b0;
            sh_cnt_q    <= '0;
            sh_inv_q    <= '0;
            slip_wait_q <= '0;
            slip_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            sh_cnt_q    <= sh_cnt_d;
            sh_inv_q    <= sh_inv_d;
            slip_wait_q <= slip_wait_d;
            // Registered so the GTX sees a clean one-cycle pulse during SLIP
            slip_q      <= (state_d == SLIP);
        end
    end

    always_ff @(posedge i_usrclk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q       <= '0;
            header_q     <= '0;
            sob_q        <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            data_q       <= bus.i_data;
            sob_q        <= test_event;
            data_valid_q <= bus.i_datavalid && lock_q;
            if (test_event) begin
                header_q <= bus.i_header;
            end
        end
    end

`ifdef RX_GEARBOX_STATS_EN
    logic [15:0] bad_cnt_q;

    always_ff @(posedge i_usrclk2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bad_cnt_q <= '0;
        end else if (test_event && hdr_invalid && lock_q && (bad_cnt_q != 16'hFFFF)) begin
            bad_cnt_q <= bad_cnt_q + 16'd1;
        end
    end

    assign bus.o_bad_header_count = bad_cnt_q;
`else
    assign bus.o_bad_header_count = 16'h0000;
`endif

    assign bus.o_rxgearboxslip  = slip_q;
    assign bus.o_block_lock     = lock_q;
    assign bus.o_data           = data_q;
    assign bus.o_header         = header_q;
    assign bus.o_start_of_block = sob_q;
    assign bus.o_data_valid     = data_valid_q;

endmodule

// File: tb/tb_external_rx_gearbox_sync.sv
// Directed bench for external_rx_gearbox_sync: lock acquisition, window tolerance,
// lock loss, slip spacing, datavalid gaps and asynchronous reset.
module tb_external_rx_gearbox_sync;

    logic i_usrclk2 = 1'b0;
    logic i_rst_n;

    external_rx_gearbox_sync_if bus ();

    external_rx_gearbox_sync #(
        .SH_CNT_MAX       (64),
        .SH_INVALID_MAX   (16),
        .SLIP_WAIT_CYCLES (32)
    ) dut (
        .i_usrclk2 (i_usrclk2),
        .i_rst_n   (i_rst_n),
        .bus       (bus)
    );

    always #5 i_usrclk2 = ~i_usrclk2;

`ifdef RX_GEARBOX_STATS_EN
    localparam logic [31:0] BAD_AFTER_5  = 32'd5;
    localparam logic [31:0] BAD_AFTER_31 = 32'd31;
`else
    localparam logic [31:0] BAD_AFTER_5  = 32'd0;
    localparam logic [31:0] BAD_AFTER_31 = 32'd0;
`endif

    int          n_pass   = 0;
    int          n_total  = 0;
    int          cyc_n    = 0;
    int          slip_cnt = 0;
    int          slip_cyc[$];
    logic [31:0] last_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: apply inputs, then sample 1 ns after the rising edge
    task automatic cyc(input logic hv, input logic dv, input logic [1:0] hdr);
        bus.i_header_valid = hv;
        bus.i_datavalid    = dv;
        bus.i_header       = hdr;
        bus.i_data         = 32'hA500_0000 ^ 32'(cyc_n);
        last_data          = bus.i_data;
        @(posedge i_usrclk2);
        #1;
        cyc_n++;
        if (bus.o_rxgearboxslip === 1'b1) begin
            slip_cnt++;
            slip_cyc.push_back(cyc_n);
        end
    endtask

    task automatic check_zero(input string ph);
        check({ph, "_lock"},   32'(bus.o_block_lock), 32'd0);
        check({ph, "_slip"},   32'(bus.o_rxgearboxslip), 32'd0);
        check({ph, "_data"},   bus.o_data, 32'd0);
        check({ph, "_header"}, 32'(bus.o_header), 32'd0);
        check({ph, "_sob"},    32'(bus.o_start_of_block), 32'd0);
        check({ph, "_dv"},     32'(bus.o_data_valid), 32'd0);
        check({ph, "_badcnt"}, 32'(bus.o_bad_header_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int s3;
        int guard;
        int g1;
        int g2;
        int lat;

        i_rst_n            = 1'b0;
        bus.i_data         = '0;
        bus.i_header       = '0;
        bus.i_header_valid = 1'b0;
        bus.i_datavalid    = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 2'b00);
        check_zero("reset");

        // Acquisition: good header every second cycle
        i_rst_n = 1'b1;
        cyc(1'b0, 1'b1, 2'b00);
        cyc(1'b0, 1'b1, 2'b00);
        for (int k = 1; k <= 64; k++) begin
            cyc(1'b1, 1'b1, 2'b01);
            if (k == 1) begin
                check("sob_event", 32'(bus.o_start_of_block), 32'd1);
                check("hdr_01", 32'(bus.o_header), 32'd1);
                check("data_reg", bus.o_data, last_data);
                check("dv_unlocked", 32'(bus.o_data_valid), 32'd0);
            end
            if (k == 63) check("lock_before_64", 32'(bus.o_block_lock), 32'd0);
            if (k == 64) check("lock_at_64", 32'(bus.o_block_lock), 32'd1);
            cyc(1'b0, 1'b1, 2'b00);
            if (k == 1)  check("sob_idle", 32'(bus.o_start_of_block), 32'd0);
            if (k == 64) check("dv_after_lock", 32'(bus.o_data_valid), 32'd1);
        end
        check("no_slip_acq", 32'(slip_cnt), 32'd0);

        // Window with 15 invalid headers plus one uncounted datavalid-low header
        for (int k = 1; k <= 64; k++) begin
            cyc(1'b1, 1'b1, (k <= 15) ? 2'b11 : 2'b01);
            if (k == 5) check("bad_cnt_5", 32'(bus.o_bad_header_count), BAD_AFTER_5);
            if (k == 20) begin
                cyc(1'b1, 1'b0, 2'b11);
                check("gap_dv", 32'(bus.o_data_valid), 32'd0);
                check("gap_sob", 32'(bus.o_start_of_block), 32'd0);
                check("gap_hdr_held", 32'(bus.o_header), 32'd1);
            end else begin
                cyc(1'b0, 1'b1, 2'b00);
            end
        end
        check("lock_after_15_invalid", 32'(bus.o_block_lock), 32'd1);
        check("no_slip_w1", 32'(slip_cnt), 32'd0);

        // Next window: 16 invalid headers drop lock
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b1, 2'b11);
            if (k == 15) check("lock_15_w2", 32'(bus.o_block_lock), 32'd1);
            if (k == 16) begin
                check("lock_drop_16", 32'(bus.o_block_lock), 32'd0);
                check("slip_after_16", 32'(bus.o_rxgearboxslip), 32'd1);
                check("dv_drop_cycle", 32'(bus.o_data_valid), 32'd1);
            end
            cyc(1'b0, 1'b1, 2'b00);
            if (k == 16) begin
                check("dv_after_drop", 32'(bus.o_data_valid), 32'd0);
                check("slip_one_cycle", 32'(bus.o_rxgearboxslip), 32'd0);
            end
        end
        check("bad_cnt_31", 32'(bus.o_bad_header_count), BAD_AFTER_31);
        repeat (3) cyc(1'b1, 1'b1, 2'b11);
        check("no_test_in_wait", 32'(slip_cnt), 32'd1);

        // Asynchronous reset while waiting after a slip
        i_rst_n = 1'b0;
        #2;
        check_zero("rst_wait");
        repeat (2) cyc(1'b0, 1'b0, 2'b00);
        i_rst_n = 1'b1;

        // Invalid headers every cycle: slips spaced by the wait period
        slip_cnt = 0;
        slip_cyc.delete();
        c0    = cyc_n;
        guard = 0;
        while (slip_cnt < 3 && guard < 300) begin
            cyc(1'b1, 1'b1, 2'b11);
            guard++;
        end
        check("three_slips", 32'(slip_cnt), 32'd3);
        g1 = (slip_cyc.size() >= 1) ? slip_cyc[0] - c0 : 0;
        check("first_slip_cycle", 32'(g1), 32'd3);
        g1 = (slip_cyc.size() >= 2) ? slip_cyc[1] - slip_cyc[0] : 0;
        g2 = (slip_cyc.size() >= 3) ? slip_cyc[2] - slip_cyc[1] : 0;
        check("slip_gap1", 32'((g1 >= 34) && (g1 <= 36)), 32'd1);
        check("slip_gap2", 32'((g2 >= 34) && (g2 <= 36)), 32'd1);

        s3    = cyc_n;
        guard = 0;
        while (bus.o_block_lock !== 1'b1 && guard < 300) begin
            cyc(1'b1, 1'b1, 2'b01);
            guard++;
        end
        lat = cyc_n - s3;
        check("relock_after_slips", 32'(bus.o_block_lock), 32'd1);
        check("total_slips", 32'(slip_cnt), 32'd3);
        check("relock_latency", 32'((lat >= 97) && (lat <= 99)), 32'd1);

        // Asynchronous reset while locked, then a full window to relock
        repeat (3) cyc(1'b1, 1'b1, 2'b01);
        check("dv_locked2", 32'(bus.o_data_valid), 32'd1);
        i_rst_n = 1'b0;
        #2;
        check_zero("rst_locked");
        repeat (2) cyc(1'b0, 1'b0, 2'b00);
        i_rst_n = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            cyc(1'b1, 1'b1, 2'b01);
            if (k == 65) check("relock_65", 32'(bus.o_block_lock), 32'd0);
            if (k == 66) check("relock_66", 32'(bus.o_block_lock), 32'd1);
        end
        check("no_slip_relock", 32'(slip_cnt), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
